// File: rtl/bmu_rsp_collector.sv
// ============================================================================
// bmu_rsp_collector
// ----------------------------------------------------------------------------
// Receive-side companion to the BMU stimulus interface. Every op issued to the
// BMU (valid_in + tag_in) is tracked through a LAT-stage valid/tag pipe. When
// the op reaches the last stage its result_ff/error are sampled and pushed,
// together with the tag, into an in-order first-word-fall-through response
// FIFO. Responses leave over a valid/ready port. A combinational issue credit
// (issue_ok) counts buffered plus in-flight ops, so an issuer that honours it
// can never overrun the FIFO.
//
// Parameters
//   LAT    cycles from valid_in sampled to result_ff/error valid (1..4)
//   DEPTH  response FIFO entries (power of 2, 2..16)
//   TAG_W  op tag width
//
// Ports
//   clk        in   clock, all state on rising edge
//   rst        in   asynchronous active-high reset
//   valid_in   in   BMU op issued this cycle
//   tag_in     in   tag of the op issued this cycle
//   result_ff  in   BMU result, valid in the landing cycle
//   error      in   BMU error, aligned with result_ff
//   flush      in   synchronous clear of pipe, FIFO and overflow flag
//   rsp_valid  out  response available (FIFO not empty)
//   rsp_ready  in   consumer accepts the head response
//   rsp_tag    out  head response tag   (0 when empty)
//   rsp_data   out  head response data  (0 when empty)
//   rsp_error  out  head response error (0 when empty)
//   issue_ok   out  credit: an op may be issued this cycle
//   inflight   out  number of ops in the latency pipe
//   overflow   out  sticky: a landing result was dropped on a full FIFO
//   err_cnt    out  saturating count of dropped error responses
//
// Configuration
//   BMU_RSP_ERR_DROP_EN  defined: error landings are not enqueued, they bump
//                        err_cnt (saturating at 255) instead, so rsp_error is
//                        always 0. Undefined: error landings are enqueued with
//                        rsp_error=1 and err_cnt stays 0.
// ============================================================================
module bmu_rsp_collector #(
    parameter int LAT   = 1,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [TAG_W-1:0] tag_in,
    input  logic [31:0]      result_ff,
    input  logic             error,
    input  logic             flush,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [31:0]      rsp_data,
    output logic             rsp_error,
    output logic             issue_ok,
    output logic [2:0]       inflight,
    output logic             overflow,
    output logic [7:0]       err_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
        logic             err;
    } rsp_t;

    // ------------------------------------------------------------------
    // Latency pipe: stage 0 takes {valid_in, tag_in} every cycle, stage
    // LAT-1 is the landing stage.
    // ------------------------------------------------------------------
    logic [LAT-1:0]            vld_pipe;
    logic [LAT-1:0][TAG_W-1:0] tag_pipe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            tag_pipe <= '0;
        end else begin
            // flush kills everything in flight, including an op issued in
            // the flush cycle itself
            vld_pipe[0] <= valid_in & ~flush;
            tag_pipe[0] <= tag_in;
            for (int i = 1; i < LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1] & ~flush;
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++)
            inflight = inflight + 3'(vld_pipe[i]);
    end

    // ------------------------------------------------------------------
    // Landing and FIFO control
    // ------------------------------------------------------------------
    logic             land;
    logic             push;
    logic             pop;
    logic             full;
    logic             push_ok;
    logic             push_lost;
    rsp_t             land_ent;
    rsp_t             head;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    rsp_t             mem [DEPTH];

    // a landing in the flush cycle is discarded
    assign land = vld_pipe[LAT-1] & ~flush;

    assign land_ent.tag  = tag_pipe[LAT-1];
    assign land_ent.data = result_ff;
    assign land_ent.err  = error;

`ifdef BMU_RSP_ERR_DROP_EN
    logic       err_drop;
    logic [7:0] err_q;

    assign err_drop = land & error;
    assign push     = land & ~error;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_q <= '0;
        else if (err_drop && err_q != 8'hff)
            err_q <= err_q + 8'd1;
    end

    assign err_cnt = err_q;
`else
    assign push    = land;
    assign err_cnt = '0;
`endif

    assign full      = (count == CNT_W'(DEPTH));
    assign pop       = rsp_valid & rsp_ready;
    // full + push + pop: the slot freed by the pop takes the new entry
    assign push_ok   = push & (~full | pop);
    assign push_lost = push & full & ~pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            // pointers are PTR_W wide, so they wrap modulo DEPTH naturally
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_lost) overflow <= 1'b1;
        end
    end

    // Storage is not reset: outputs are gated by count, so stale contents
    // are never visible.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= land_ent;
    end

    assign head = mem[rd_ptr];

    // ------------------------------------------------------------------
    // Response port and issue credit
    // ------------------------------------------------------------------
    always_comb begin
        rsp_valid = (count != '0);
        rsp_tag   = '0;
        rsp_data  = '0;
        rsp_error = 1'b0;
        if (rsp_valid) begin
            rsp_tag   = head.tag;
            rsp_data  = head.data;
            rsp_error = head.err;
        end
    end

    // Buffered plus in-flight ops must leave room for the op issued now.
    logic [7:0] occupancy;
    assign occupancy = 8'(count) + 8'(inflight);
    assign issue_ok  = (occupancy < 8'(DEPTH));

endmodule

// File: tb/tb_bmu_rsp_collector.sv
module tb_bmu_rsp_collector;

    localparam int LAT   = 1;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             valid_in = 1'b0;
    logic [TAG_W-1:0] tag_in = '0;
    logic [31:0]      result_ff = '0;
    logic             error = 1'b0;
    logic             flush = 1'b0;
    logic             rsp_ready = 1'b0;
    logic             rsp_valid;
    logic [TAG_W-1:0] rsp_tag;
    logic [31:0]      rsp_data;
    logic             rsp_error;
    logic             issue_ok;
    logic [2:0]       inflight;
    logic             overflow;
    logic [7:0]       err_cnt;

    bmu_rsp_collector #(.LAT(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .tag_in(tag_in),
        .result_ff(result_ff), .error(error), .flush(flush),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag),
        .rsp_data(rsp_data), .rsp_error(rsp_error), .issue_ok(issue_ok),
        .inflight(inflight), .overflow(overflow), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (queues, spec-level) ----------------
    typedef struct { logic [TAG_W-1:0] tag; int land; } pend_t;
    typedef struct { logic [TAG_W-1:0] tag; logic [31:0] data; logic err; } ent_t;

    pend_t pend[$];   // issued ops not yet landed, with landing cycle
    ent_t  fq[$];     // buffered responses, head first
    bit    m_ovf;
    int    m_errc;
    int    cyc;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h, want %0h", nm, obs, exp);
        end
    endtask

    function automatic bit m_ok();
        return (fq.size() + pend.size()) < DEPTH;
    endfunction

    task automatic m_reset();
        pend.delete();
        fq.delete();
        m_ovf  = 0;
        m_errc = 0;
    endtask

    task automatic drive(input bit v, input logic [TAG_W-1:0] t, input logic [31:0] d,
                         input bit e, input bit f, input bit r);
        valid_in  = v;
        tag_in    = t;
        result_ff = d;
        error     = e;
        flush     = f;
        rsp_ready = r;
    endtask

    // Called at a falling edge with inputs already driven: compare outputs
    // against the model, then advance the model across the rising edge.
    task automatic tick();
        ent_t e;
        bit   pop;
        #1;
        check("rsp_valid", rsp_valid, fq.size() > 0);
        if (fq.size() > 0) begin
            check("rsp_tag",   rsp_tag,   fq[0].tag);
            check("rsp_data",  rsp_data,  fq[0].data);
            check("rsp_error", rsp_error, fq[0].err);
        end
        check("issue_ok", issue_ok, m_ok());
        check("inflight", inflight, pend.size());
        check("overflow", overflow, m_ovf);
        check("err_cnt",  err_cnt,  m_errc);
        @(posedge clk);
        if (flush) begin
            pend.delete();
            fq.delete();
            m_ovf = 0;
        end else begin
            pop = (fq.size() > 0) && rsp_ready;
            if (pop) void'(fq.pop_front());
            if (pend.size() > 0 && pend[0].land == cyc) begin
                e.tag  = pend[0].tag;
                e.data = result_ff;
                e.err  = error;
                void'(pend.pop_front());
`ifdef BMU_RSP_ERR_DROP_EN
                if (e.err) begin
                    if (m_errc < 255) m_errc++;
                end else
`endif
                if (fq.size() < DEPTH) fq.push_back(e);
                else m_ovf = 1;
            end
            if (valid_in) pend.push_back('{tag: tag_in, land: cyc + LAT});
        end
        cyc++;
        @(negedge clk);
    endtask

    // Issue while the model credit allows, consumer stalled.
    task automatic fill(input int base);
        for (int i = 0; i < 8; i++) begin
            drive(m_ok(), TAG_W'(base + i), $urandom, 1'b0, 1'b0, 1'b0);
            tick();
        end
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) begin
            drive(1'b0, '0, $urandom, 1'b0, 1'b0, 1'b1);
            tick();
        end
    endtask

    initial begin
        m_reset();
        cyc = 0;

        // ---- reset values ----
        @(negedge clk);
        #1;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_tag",   rsp_tag,   0);
        check("rst_rsp_data",  rsp_data,  0);
        check("rst_rsp_error", rsp_error, 0);
        check("rst_issue_ok",  issue_ok,  1);
        check("rst_inflight",  inflight,  0);
        check("rst_overflow",  overflow,  0);
        check("rst_err_cnt",   err_cnt,   0);
        @(negedge clk);
        rst = 1'b0;

        // ---- 1: single op, tag 3, DEADBEEF ----
        drive(1'b1, 4'd3, 32'h0, 1'b0, 1'b0, 1'b1); tick();
        drive(1'b0, 4'd0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1); tick();
        #1;
        check("t1_valid_lat2", rsp_valid, 1);
        check("t1_tag", rsp_tag, 3);
        check("t1_data", rsp_data, 32'hDEADBEEF);
        drive(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b1); tick();
        check("t1_empty", rsp_valid, 0);

        // ---- 2: back-to-back under credit, stalled consumer ----
        fill(4);
        #1;
        check("t2_full_valid", rsp_valid, 1);
        check("t2_issue_ok",   issue_ok, 0);
        check("t2_overflow",   overflow, 0);
        check("t2_head_tag",   rsp_tag, 4);
        drain();

        // ---- 3: forced landing on full FIFO, then flush ----
        fill(8);
        drive(1'b1, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b0, 4'h0, 32'h5555, 1'b0, 1'b0, 1'b0); tick();
        #1;
        check("t3_overflow", overflow, 1);
        check("t3_head_tag", rsp_tag, 8);
        drive(1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 1'b0); tick();
        #1;
        check("t3_flush_valid", rsp_valid, 0);
        check("t3_flush_ovf",   overflow, 0);

        // ---- 4: full FIFO, landing and pop in the same cycle ----
        fill(1);
        drive(1'b1, 4'hA, 32'h0, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b0, 4'h0, 32'h44, 1'b0, 1'b0, 1'b1); tick();
        drive(1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0); tick();
        #1;
        check("t4_overflow", overflow, 0);
        check("t4_issue_ok", issue_ok, 0);
        drain();

        // ---- 5: error landing ----
        drive(1'b1, 4'h6, 32'h0, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0); tick();
        #1;
`ifdef BMU_RSP_ERR_DROP_EN
        check("t5_no_valid", rsp_valid, 0);
        check("t5_err_cnt",  err_cnt, 1);
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, TAG_W'(i), $urandom, 1'b1, 1'b0, 1'b1);
            tick();
        end
        drive(1'b0, '0, 32'h0, 1'b0, 1'b0, 1'b1); tick();
        check("t5_err_sat", err_cnt, 255);
`else
        check("t5_rsp_error", rsp_error, 1);
        check("t5_err_cnt",   err_cnt, 0);
`endif
        drain();

        // ---- 6: reset with buffered and in-flight ops ----
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, TAG_W'(12 + i), $urandom, 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, '0, $urandom, 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rsp_valid", rsp_valid, 0);
        check("t6_rsp_tag",   rsp_tag,   0);
        check("t6_rsp_data",  rsp_data,  0);
        check("t6_inflight",  inflight,  0);
        check("t6_overflow",  overflow,  0);
        check("t6_err_cnt",   err_cnt,   0);
        check("t6_issue_ok",  issue_ok,  1);
        m_reset();
        @(negedge clk);
        rst = 1'b0;
        cyc++;
        drain();

        // ---- 7: randomized traffic ----
        for (int i = 0; i < 800; i++) begin
            bit v;
            v = m_ok() ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 15) == 0);
            drive(v, TAG_W'($urandom), $urandom, ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 49) == 0), ($urandom_range(0, 2) != 0));
            tick();
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
